fff_round_ctrl: RTL and testbench

FFF_ROUND_CTRL -- requirements
Module: fff_round_ctrl

---
 rtl/fff_round_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fff_round_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fff_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fff_round_ctrl
// Description : Fastest-finger-first round controller for ten contestants.
//               Synchronizes the raw button inputs, opens an answer window
//               on host request, latches the first (lowest-index) press,
//               drives a fixed-length buzzer pulse and reports expiry when
//               the window closes without a press.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYC : answer-window length in clk cycles (1..65535)
//   BUZZ_CYC    : buzzer pulse length in clk cycles (1..255)
// Ports
//   clk      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous active-low reset
//   arm      in   1  host request to open a round (level or pulse)
//   clear    in   1  host request to end the round and return to idle
//   btn_n    in  10  raw active-low buttons, asynchronous; bit i = player i+1
//   winner_n out  4  active-low winner code, 4'b1111 = none
//   armed    out  1  round open
//   locked   out  1  winner held
//   timeout  out  1  round expired with no press
//   buzz     out  1  buzzer drive, BUZZ_CYC cycles from lock
// ============================================================================
module fff_round_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned BUZZ_CYC    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       clear,
  input  logic [9:0] btn_n,
  output logic [3:0] winner_n,
  output logic       armed,
  output logic       locked,
  output logic       timeout,
  output logic       buzz
);

  localparam int unsigned NUM_BTN       = 10;
  localparam logic [15:0] C_WINDOW_LOAD = 16'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  C_BUZZ_LOAD   = 8'(BUZZ_CYC - 1);
  localparam logic [3:0]  C_NO_WINNER   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Button synchronizer (two flops per bit, idle-high)
  // --------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_meta_q;
  logic [NUM_BTN-1:0] btn_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '1;
      btn_sync_q <= '1;
    end else begin
      btn_meta_q <= btn_n;
      btn_sync_q <= btn_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Lowest-index press encoder. Scanning from the top down lets the lowest
  // pressed bit overwrite any higher one, so simultaneous presses resolve to
  // the smallest player number.
  // --------------------------------------------------------------------------
  logic       w_any_press;
  logic [3:0] w_press_code;

  always_comb begin
    w_any_press  = 1'b0;
    w_press_code = C_NO_WINNER;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (!btn_sync_q[i]) begin
        w_any_press  = 1'b1;
        w_press_code = ~(4'(i + 1));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round state
  // --------------------------------------------------------------------------
  state_t      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [7:0]  buzz_cnt_q, buzz_cnt_d;
  logic [3:0]  winner_q,   winner_d;
  logic        buzz_q,     buzz_d;
  logic        armed_q;
  logic        locked_q;
  logic        timeout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buzz_cnt_d = buzz_cnt_q;
    winner_d   = winner_q;
    buzz_d     = buzz_q;

    if (clear) begin
      // Clear outranks everything, including a simultaneous arm.
      state_d    = S_IDLE;
      cnt_d      = '0;
      buzz_cnt_d = '0;
      winner_d   = C_NO_WINNER;
      buzz_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A button already low at arm time is an early or stuck press;
          // the round is not opened.
          if (arm && (&btn_sync_q)) begin
            state_d = S_ARMED;
            cnt_d   = C_WINDOW_LOAD;
          end
        end

        S_ARMED: begin
          // Press is tested before the count so a press on the last
          // window cycle still wins.
          if (w_any_press) begin
            state_d    = S_LOCKED;
            cnt_d      = '0;
            winner_d   = w_press_code;
            buzz_d     = 1'b1;
            buzz_cnt_d = C_BUZZ_LOAD;
          end else if (cnt_q == 16'd0) begin
            state_d = S_EXPIRED;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        S_LOCKED: begin
          // buzz_cnt holds the number of high cycles still to come after
          // the current one.
          if (buzz_q) begin
            if (buzz_cnt_q == 8'd0) begin
              buzz_d = 1'b0;
            end else begin
              buzz_cnt_d = buzz_cnt_q - 8'd1;
            end
          end
        end

        S_EXPIRED: begin
          // Held until clear.
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      buzz_cnt_q <= '0;
      winner_q   <= C_NO_WINNER;
      buzz_q     <= 1'b0;
      armed_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buzz_cnt_q <= buzz_cnt_d;
      winner_q   <= winner_d;
      buzz_q     <= buzz_d;
      // Status flags are decoded from the next state so they change on
      // the same edge as the state itself and stay one-hot-or-zero.
      armed_q    <= (state_d == S_ARMED);
      locked_q   <= (state_d == S_LOCKED);
      timeout_q  <= (state_d == S_EXPIRED);
    end
  end

  assign winner_n = winner_q;
  assign armed    = armed_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;
  assign buzz     = buzz_q;

endmodule
`default_nettype wire

// File: tb/tb_fff_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fff_round_ctrl
// Description : Self-checking bench for fff_round_ctrl with directed
//               scenarios and a randomized run against a cycle-level
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fff_round_ctrl;

  localparam int unsigned T_CYC = 4;
  localparam int unsigned B_CYC = 8;

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_LOCKED  = 2;
  localparam int M_EXPIRED = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       clear;
  logic [9:0] btn_n;
  logic [3:0] winner_n;
  logic       armed;
  logic       locked;
  logic       timeout;
  logic       buzz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fff_round_ctrl #(
    .TIMEOUT_CYC (T_CYC),
    .BUZZ_CYC    (B_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .clear    (clear),
    .btn_n    (btn_n),
    .winner_n (winner_n),
    .armed    (armed),
    .locked   (locked),
    .timeout  (timeout),
    .buzz     (buzz)
  );

  // --------------------------------------------------------------------------
  // Reference model: absolute edge numbers instead of down-counters.
  // A button value reaches the decision logic two edges after it is sampled.
  // --------------------------------------------------------------------------
  int          m_mode;
  int unsigned m_cyc;
  int unsigned m_arm_cyc;
  int unsigned m_buzz_end;
  logic [9:0]  m_h1, m_h2;
  logic [3:0]  m_win;

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_buzz_end = 0;
    m_h1       = '1;
    m_h2       = '1;
    m_win      = 4'b1111;
  endtask

  task automatic model_edge();
    logic [9:0] seen;
    logic [3:0] code;
    bit         found;
    m_cyc = m_cyc + 1;
    seen  = m_h2;
    m_h2  = m_h1;
    m_h1  = btn_n;
    found = 1'b0;
    code  = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      if (!found && !seen[i]) begin
        found = 1'b1;
        code  = 4'(i + 1);
        code  = ~code;
      end
    end
    if (clear) begin
      m_mode     = M_IDLE;
      m_win      = 4'b1111;
      m_buzz_end = 0;
    end else if (m_mode == M_IDLE) begin
      if (arm && seen == 10'h3FF) begin
        m_mode    = M_ARMED;
        m_arm_cyc = m_cyc;
      end
    end else if (m_mode == M_ARMED) begin
      if (found) begin
        m_mode     = M_LOCKED;
        m_win      = code;
        m_buzz_end = m_cyc + B_CYC;
      end else if (m_cyc - m_arm_cyc == T_CYC) begin
        m_mode = M_EXPIRED;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    arm   = 1'b0;
    clear = 1'b0;
    btn_n = '1;
    m_cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (winner_n !== 4'b1111) begin errors++; $display("FAIL reset_winner got %b exp 1111", winner_n); end
    checks++; if (armed !== 1'b0)       begin errors++; $display("FAIL reset_armed got %b exp 0", armed); end
    checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (timeout !== 1'b0)     begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (buzz !== 1'b0)        begin errors++; $display("FAIL reset_buzz got %b exp 0", buzz); end
    #4 rst_n = 1'b1;
    tick(3);
    checks++; if ({armed, locked, timeout, buzz} !== 4'b0000) begin
      errors++; $display("FAIL post_reset_idle got %b exp 0000", {armed, locked, timeout, buzz});
    end
  endtask

  task automatic test_lock_basic();
    int hi;
    arm = 1'b1; tick(1); arm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL basic_armed got %b exp 1", armed); end
    btn_n = 10'b11_1111_1011;
    tick(2);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_latency got %b exp 0", locked); end
    tick(1);
    checks++; if (locked !== 1'b1)        begin errors++; $display("FAIL basic_locked got %b exp 1", locked); end
    checks++; if (winner_n !== 4'b1100)   begin errors++; $display("FAIL basic_winner got %b exp 1100", winner_n); end
    checks++; if (armed !== 1'b0)         begin errors++; $display("FAIL basic_armed_off got %b exp 0", armed); end
    checks++; if (buzz !== 1'b1)          begin errors++; $display("FAIL basic_buzz_rise got %b exp 1", buzz); end
    hi = 1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (buzz === 1'b1) hi++;
    end
    checks++; if (hi != B_CYC) begin errors++; $display("FAIL basic_buzz_len got %0d exp %0d", hi, B_CYC); end
    checks++; if (winner_n !== 4'b1100 || locked !== 1'b1) begin
      errors++; $display("FAIL basic_hold got %b/%b exp 1100/1", winner_n, locked);
    end
    btn_n = '1; clear = 1'b1; tick(1); clear = 1'b0;
    checks++; if (locked !== 1'b0 || winner_n !== 4'b1111) begin
      errors++; $display("FAIL basic_clear got %b/%b exp 0/1111", locked, winner_n);
    end
    tick(2);
  endtask

  task automatic test_simultaneous();
    arm = 1'b1; tick(1); arm = 1'b0;
    btn_n = 10'b01_1110_1111; tick(1);
    btn_n = '1; tick(2);
    checks++; if (locked !== 1'b1 || winner_n !== 4'b1010) begin
      errors++; $display("FAIL simul_winner got %b/%b exp 1/1010", locked, winner_n);
    end
    btn_n = 10'b11_1111_1110; tick(4);
    checks++; if (winner_n !== 4'b1010) begin errors++; $display("FAIL simul_late_press got %b exp 1010", winner_n); end
    btn_n = '1; clear = 1'b1; tick(1); clear = 1'b0; tick(2);
  endtask

  task automatic test_timeout();
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(3);
    checks++; if (timeout !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL to_early got %b/%b exp 0/1", timeout, armed);
    end
    tick(1);
    checks++; if (timeout !== 1'b1 || armed !== 1'b0 || winner_n !== 4'b1111) begin
      errors++; $display("FAIL to_expire got %b/%b/%b exp 1/0/1111", timeout, armed, winner_n);
    end
    arm = 1'b1; btn_n = 10'b11_1111_0000; tick(4);
    checks++; if (timeout !== 1'b1 || locked !== 1'b0 || winner_n !== 4'b1111) begin
      errors++; $display("FAIL to_hold got %b/%b/%b exp 1/0/1111", timeout, locked, winner_n);
    end
    arm = 1'b0; btn_n = '1; clear = 1'b1; tick(1); clear = 1'b0; tick(2);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout); end
    // press seen on the final-count cycle
    arm = 1'b1; tick(1); arm = 1'b0;
    tick(1);
    btn_n = 10'b11_0111_1111; tick(2);
    checks++; if (locked !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL to_last_pre got %b/%b exp 0/1", locked, armed);
    end
    tick(1);
    checks++; if (locked !== 1'b1 || timeout !== 1'b0 || winner_n !== 4'b0111) begin
      errors++; $display("FAIL to_last_press got %b/%b/%b exp 1/0/0111", locked, timeout, winner_n);
    end
    btn_n = '1; clear = 1'b1; tick(1); clear = 1'b0; tick(2);
  endtask

  task automatic test_early_press();
    btn_n = 10'b11_1111_1011; tick(3);
    arm = 1'b1; tick(1); arm = 1'b0; tick(1);
    checks++; if (armed !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL early_refused got %b/%b exp 0/0", armed, locked);
    end
    btn_n = '1; tick(3);
    arm = 1'b1; tick(1); arm = 1'b0;
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL early_rearm got %b exp 1", armed); end
    clear = 1'b1; tick(1); clear = 1'b0;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL early_clear got %b exp 0", armed); end
  endtask

  task automatic test_clear_priority();
    arm = 1'b1; tick(1); arm = 1'b0;
    btn_n = 10'b01_1111_1111; tick(3);
    checks++; if (locked !== 1'b1 || winner_n !== 4'b0101 || buzz !== 1'b1) begin
      errors++; $display("FAIL clr_lock got %b/%b/%b exp 1/0101/1", locked, winner_n, buzz);
    end
    tick(2);
    checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL clr_buzz3 got %b exp 1", buzz); end
    btn_n = '1; clear = 1'b1; tick(1); clear = 1'b0;
    checks++; if (buzz !== 1'b0 || winner_n !== 4'b1111 || locked !== 1'b0 || armed !== 1'b0) begin
      errors++; $display("FAIL clr_trunc got %b/%b/%b/%b exp 0/1111/0/0", buzz, winner_n, locked, armed);
    end
    tick(2);
    arm = 1'b1; clear = 1'b1; tick(1); arm = 1'b0; clear = 1'b0;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL clr_arm_idle got %b exp 0", armed); end
    arm = 1'b1; tick(1);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL clr_arm_open got %b exp 1", armed); end
    clear = 1'b1; tick(1); arm = 1'b0; clear = 1'b0;
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL clr_arm_armed got %b exp 0", armed); end
  endtask

  task automatic test_async_reset();
    arm = 1'b1; tick(1); arm = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({armed, locked, timeout, buzz, winner_n} !== 8'b0000_1111) begin
      errors++; $display("FAIL arst_armed got %b exp 00001111", {armed, locked, timeout, buzz, winner_n});
    end
    #1 rst_n = 1'b1;
    model_reset();
    tick(1);
    arm = 1'b1; tick(1); arm = 1'b0;
    btn_n = 10'b11_1101_1111; tick(4);
    checks++; if (locked !== 1'b1 || buzz !== 1'b1) begin
      errors++; $display("FAIL arst_prelock got %b/%b exp 1/1", locked, buzz);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({armed, locked, timeout, buzz, winner_n} !== 8'b0000_1111) begin
      errors++; $display("FAIL arst_locked got %b exp 00001111", {armed, locked, timeout, buzz, winner_n});
    end
    btn_n = '1;
    #1 rst_n = 1'b1;
    model_reset();
    tick(3);
    checks++; if (buzz !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL arst_no_buzz got %b/%b exp 0/0", buzz, locked);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      arm   = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r == 7)      btn_n = ~(10'd1 << $urandom_range(0, 9));
      else if (r == 8) btn_n = 10'($urandom);
      else if (r < 7)  btn_n = '1;
      tick(1);
      checks++;
      if (armed !== (m_mode == M_ARMED) || locked !== (m_mode == M_LOCKED) ||
          timeout !== (m_mode == M_EXPIRED) || buzz !== (m_cyc < m_buzz_end) ||
          winner_n !== m_win) begin
        errors++;
        $display("FAIL rand_cycle%0d got a%b l%b t%b b%b w%b exp a%b l%b t%b b%b w%b", n,
                 armed, locked, timeout, buzz, winner_n,
                 (m_mode == M_ARMED), (m_mode == M_LOCKED), (m_mode == M_EXPIRED),
                 (m_cyc < m_buzz_end), m_win);
      end
    end
    arm = 1'b0; clear = 1'b0; btn_n = '1;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_simultaneous();
    test_timeout();
    test_early_press();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
